// File: rtl/irencoder_wb8_pkg.sv
// Shared NEC infrared timing definitions and register map for irencoder_wb8.
// No ports: provides the NEC unit durations (in 562.5 us ticks), the tick
// length formula and the register addresses.
package irencoder_wb8_pkg;

   // NEC segment lengths in units of 562.5 us
   localparam int unsigned NEC_HDR_MARK   = 16;
   localparam int unsigned NEC_HDR_SPACE  = 8;
   localparam int unsigned NEC_REP_SPACE  = 4;
   localparam int unsigned NEC_BIT_MARK   = 1;
   localparam int unsigned NEC_ZERO_SPACE = 1;
   localparam int unsigned NEC_ONE_SPACE  = 3;
   localparam int unsigned NEC_STOP_MARK  = 1;
   localparam int unsigned NEC_GUARD      = 72;
   localparam int unsigned NEC_FRAME_BITS = 32;

   // Register map
   localparam logic [1:0] REG_ADDR = 2'd0;
   localparam logic [1:0] REG_CMD  = 2'd1;
   localparam logic [1:0] REG_CTRL = 2'd2;

   // Clock cycles in one 562.5 us unit (truncated)
   function automatic int unsigned nec_tick_cycles(input int unsigned clockfreq);
      return (clockfreq * 9) / 16000;
   endfunction

endpackage

// File: rtl/irencoder_wb8_if.sv
// Wishbone 8-bit responder bus bundle for irencoder_wb8.
// Signals: I_wb_adr (register select), I_wb_dat (write data), I_wb_stb,
// I_wb_we, O_wb_dat (read data), O_wb_ack. The clock stays a plain port.
interface irencoder_wb8_if;

   logic [1:0] I_wb_adr;
   logic [7:0] I_wb_dat;
   logic       I_wb_stb;
   logic       I_wb_we;
   logic [7:0] O_wb_dat;
   logic       O_wb_ack;

   modport master (
      output I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
      input  O_wb_dat, O_wb_ack
   );

   modport slave (
      input  I_wb_adr, I_wb_dat, I_wb_stb, I_wb_we,
      output O_wb_dat, O_wb_ack
   );

endinterface

// File: rtl/ir_carrier.sv
// IR carrier phase generator: counts 0..CPER-1 and wraps while enabled.
// Ports: clk, rst (sync active-high), restart (sync, forces phase 0),
// en (advance counter), high_c (combinational: counter in high phase).
module ir_carrier #(
   parameter int unsigned CPER  = 661,
   parameter int unsigned CHIGH = 220
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic en,
   output logic high_c
);

   localparam int unsigned CW = (CPER > 1) ? $clog2(CPER) : 1;

   logic [CW-1:0] cnt;

   // Period counter; restart wins over enable so each mark starts high
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == CW'(CPER - 1)) cnt <= '0;
         else                      cnt <= cnt + CW'(1);
      end
   end

   assign high_c = (32'(cnt) < CHIGH);

endmodule

// File: rtl/irencoder_wb8.sv
// NEC infrared transmitter with a Wishbone 8-bit register interface.
// Ports: I_wb_clk (bus clock), I_reset (sync active-high), wb (Wishbone
// slave bundle: adr/dat/stb/we in, dat/ack out), O_ir_led (modulated LED
// drive, inverted when INVERT=1).
// Registers: 0 ADDR r/w, 1 CMD r/w, 2 CTRL write {repeat,frame} / read busy,
// 3 reads zero.
module irencoder_wb8
   import irencoder_wb8_pkg::*;
#(
   parameter int unsigned CLOCKFREQ   = 25125000,
   parameter int unsigned CARRIERFREQ = 38000,
   parameter bit          INVERT      = 1'b0
) (
   input  logic           I_wb_clk,
   input  logic           I_reset,
   irencoder_wb8_if.slave wb,
   output logic           O_ir_led
);

   localparam int unsigned TICK  = nec_tick_cycles(CLOCKFREQ);
   localparam int unsigned CPER  = CLOCKFREQ / CARRIERFREQ;
   localparam int unsigned CHIGH = CPER / 3;

   localparam int unsigned CYC_HDR_MARK   = NEC_HDR_MARK   * TICK;
   localparam int unsigned CYC_HDR_SPACE  = NEC_HDR_SPACE  * TICK;
   localparam int unsigned CYC_REP_SPACE  = NEC_REP_SPACE  * TICK;
   localparam int unsigned CYC_BIT_MARK   = NEC_BIT_MARK   * TICK;
   localparam int unsigned CYC_ZERO_SPACE = NEC_ZERO_SPACE * TICK;
   localparam int unsigned CYC_ONE_SPACE  = NEC_ONE_SPACE  * TICK;
   localparam int unsigned CYC_STOP_MARK  = NEC_STOP_MARK  * TICK;
   localparam int unsigned CYC_GUARD      = NEC_GUARD      * TICK;
   localparam int unsigned CNT_W          = $clog2(CYC_GUARD + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_MARK,
      ST_HDR_SPACE,
      ST_REP_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP_MARK,
      ST_GUARD
   } state_t;

   function automatic logic is_mark(input state_t s);
      return (s == ST_HDR_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
   endfunction

   state_t          state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, dur_c;
   logic [4:0]      bit_cnt, bit_cnt_d;
   logic [31:0]     shift, shift_d;
   logic            rep, rep_d;
   logic [7:0]      addr_q, cmd_q, dat_q, rdata_c;
   logic            ack_q, led_q;
   logic            wr_c, ctrl_wr_c, busy_c, seg_end_c;
   logic            restart_c, carrier_high_c;

   assign wr_c      = wb.I_wb_stb && wb.I_wb_we;
   assign ctrl_wr_c = wr_c && (wb.I_wb_adr == REG_CTRL);
   assign busy_c    = (state != ST_IDLE);
   assign seg_end_c = (cnt == dur_c - CNT_W'(1));

   // Length of the current state in clock cycles
   always_comb begin
      dur_c = CNT_W'(1);
      case (state)
         ST_HDR_MARK:  dur_c = CNT_W'(CYC_HDR_MARK);
         ST_HDR_SPACE: dur_c = CNT_W'(CYC_HDR_SPACE);
         ST_REP_SPACE: dur_c = CNT_W'(CYC_REP_SPACE);
         ST_BIT_MARK:  dur_c = CNT_W'(CYC_BIT_MARK);
         ST_BIT_SPACE: dur_c = shift[0] ? CNT_W'(CYC_ONE_SPACE) : CNT_W'(CYC_ZERO_SPACE);
         ST_STOP_MARK: dur_c = CNT_W'(CYC_STOP_MARK);
         ST_GUARD:     dur_c = CNT_W'(CYC_GUARD);
         default:      dur_c = CNT_W'(1);
      endcase
   end

   // Frame sequencer: next state, cycle counter, bit shifter
   always_comb begin
      state_d   = state;
      cnt_d     = cnt + CNT_W'(1);
      bit_cnt_d = bit_cnt;
      shift_d   = shift;
      rep_d     = rep;
      restart_c = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_d = '0;
            if (ctrl_wr_c && (wb.I_wb_dat[0] || wb.I_wb_dat[1])) begin
               state_d   = ST_HDR_MARK;
               rep_d     = ~wb.I_wb_dat[0];
               shift_d   = {~cmd_q, cmd_q, ~addr_q, addr_q};
               bit_cnt_d = '0;
            end
         end
         ST_HDR_MARK:  if (seg_end_c) state_d = rep ? ST_REP_SPACE : ST_HDR_SPACE;
         ST_HDR_SPACE: if (seg_end_c) state_d = ST_BIT_MARK;
         ST_REP_SPACE: if (seg_end_c) state_d = ST_STOP_MARK;
         ST_BIT_MARK:  if (seg_end_c) state_d = ST_BIT_SPACE;
         ST_BIT_SPACE: begin
            if (seg_end_c) begin
               shift_d   = {1'b0, shift[31:1]};
               bit_cnt_d = bit_cnt + 5'd1;
               state_d   = (bit_cnt == 5'(NEC_FRAME_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
            end
         end
         ST_STOP_MARK: if (seg_end_c) state_d = ST_GUARD;
         ST_GUARD:     if (seg_end_c) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
      if (state_d != state) cnt_d = '0;
      restart_c = is_mark(state_d) && (state_d != state);
   end

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         rep     <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_cnt <= bit_cnt_d;
         shift   <= shift_d;
         rep     <= rep_d;
      end
   end

   // Register read mux
   always_comb begin
      rdata_c = 8'h00;
      case (wb.I_wb_adr)
         REG_ADDR: rdata_c = addr_q;
         REG_CMD:  rdata_c = cmd_q;
         REG_CTRL: rdata_c = {7'b0, busy_c};
         default:  rdata_c = 8'h00;
      endcase
   end

   // Bus registers: ack follows every strobe cycle by one clock
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         addr_q <= 8'h00;
         cmd_q  <= 8'h00;
         dat_q  <= 8'h00;
         ack_q  <= 1'b0;
      end else begin
         ack_q <= wb.I_wb_stb;
         if (wb.I_wb_stb) dat_q <= rdata_c;
         if (wr_c && (wb.I_wb_adr == REG_ADDR)) addr_q <= wb.I_wb_dat;
         if (wr_c && (wb.I_wb_adr == REG_CMD))  cmd_q  <= wb.I_wb_dat;
      end
   end

   ir_carrier #(
      .CPER  (CPER),
      .CHIGH (CHIGH)
   ) u_carrier (
      .clk     (I_wb_clk),
      .rst     (I_reset),
      .restart (restart_c),
      .en      (is_mark(state)),
      .high_c  (carrier_high_c)
   );

   // LED drive lags the state by one cycle
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) led_q <= INVERT;
      else         led_q <= INVERT ^ (is_mark(state) && carrier_high_c);
   end

   assign wb.O_wb_dat = dat_q;
   assign wb.O_wb_ack = ack_q;
   assign O_ir_led    = led_q;

endmodule

// File: tb/tb_irencoder_wb8.sv
// Bench for irencoder_wb8: two instances (INVERT=0 and INVERT=1) share the
// same stimulus; LED levels are logged each cycle and compared against an
// NEC waveform built from segment lists.
module tb_irencoder_wb8;

   localparam int CLOCKFREQ   = 32000;
   localparam int CARRIERFREQ = 4000;
   localparam int TICK        = CLOCKFREQ * 9 / 16000;
   localparam int CPER        = CLOCKFREQ / CARRIERFREQ;
   localparam int CHIGH       = CPER / 3;
   localparam int LOG_N       = 32768;

   logic clk, rst, led0, led1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   last_edge = 0;
   bit   log0 [LOG_N];
   bit   log1 [LOG_N];
   int   seg_mark [$];
   int   seg_len  [$];
   logic [7:0] m_addr, m_cmd;

   irencoder_wb8_if wb0 ();
   irencoder_wb8_if wb1 ();

   irencoder_wb8 #(.CLOCKFREQ(CLOCKFREQ), .CARRIERFREQ(CARRIERFREQ), .INVERT(1'b0)) dut (
      .I_wb_clk (clk), .I_reset (rst), .wb (wb0.slave), .O_ir_led (led0));

   irencoder_wb8 #(.CLOCKFREQ(CLOCKFREQ), .CARRIERFREQ(CARRIERFREQ), .INVERT(1'b1)) dut_inv (
      .I_wb_clk (clk), .I_reset (rst), .wb (wb1.slave), .O_ir_led (led1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOG_N) begin
         log0[cyc] = led0;
         log1[cyc] = led1;
      end
   end

   initial begin
      #(LOG_N * 10);
      $display("FAIL watchdog: simulation ran past %0d cycles", LOG_N);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic stb, input logic we, input logic [1:0] adr, input logic [7:0] d);
      wb0.I_wb_stb = stb; wb0.I_wb_we = we; wb0.I_wb_adr = adr; wb0.I_wb_dat = d;
      wb1.I_wb_stb = stb; wb1.I_wb_we = we; wb1.I_wb_adr = adr; wb1.I_wb_dat = d;
   endtask

   // Called and returns at posedge+1; the access is sampled on the next edge
   task automatic bus(input logic we, input logic [1:0] adr, input logic [7:0] d,
                      output logic [7:0] rd);
      drive(1'b1, we, adr, d);
      @(posedge clk); #1;
      last_edge = cyc;
      drive(1'b0, 1'b0, 2'd0, 8'h00);
      @(negedge clk);
      check("ack", 32'(wb0.O_wb_ack), 1);
      rd = wb0.O_wb_dat;
      @(posedge clk); #1;
      check("ack_single", 32'(wb0.O_wb_ack), 0);
   endtask

   task automatic wr(input logic [1:0] adr, input logic [7:0] d);
      logic [7:0] r;
      bus(1'b1, adr, d, r);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] adr, input logic [7:0] exp);
      logic [7:0] r;
      bus(1'b0, adr, 8'h00, r);
      check(tag, 32'(r), 32'(exp));
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic void add_seg(input int mark, input int ticks);
      seg_mark.push_back(mark);
      seg_len.push_back(ticks);
   endfunction

   // NEC frame as alternating mark/space segments, lengths in 562.5 us units
   function automatic void build_frame(input bit rep, input logic [7:0] a, input logic [7:0] c);
      logic [31:0] w;
      seg_mark.delete();
      seg_len.delete();
      add_seg(1, 16);
      if (rep) begin
         add_seg(0, 4);
      end else begin
         add_seg(0, 8);
         w = {~c, c, ~a, a};
         for (int i = 0; i < 32; i++) begin
            add_seg(1, 1);
            add_seg(0, w[i] ? 3 : 1);
         end
      end
      add_seg(1, 1);
      add_seg(0, 72);
   endfunction

   function automatic int frame_cycles();
      int s;
      s = 0;
      foreach (seg_len[i]) s += seg_len[i] * TICK;
      return s;
   endfunction

   function automatic bit exp_level(input int t);
      int base;
      int n;
      base = 0;
      for (int i = 0; i < seg_len.size(); i++) begin
         n = seg_len[i] * TICK;
         if (t < base + n) return (seg_mark[i] != 0) && (((t - base) % CPER) < CHIGH);
         base += n;
      end
      return 1'b0;
   endfunction

   // Compare logged LED against the model; the LED lags the frame by one cycle
   task automatic check_wave(input string tag, input int start, input int extra);
      int total;
      int errs;
      int ierrs;
      bit e;
      total = frame_cycles();
      errs = 0;
      ierrs = 0;
      wait_to(start + total + extra + 1);
      for (int j = 0; j <= total + extra; j++) begin
         e = (j >= 1) ? exp_level(j - 1) : 1'b0;
         if (log0[start + j] != e) errs++;
         if (log1[start + j] == log0[start + j]) ierrs++;
      end
      check({tag, "_wave_err"}, 32'(errs), 0);
      check({tag, "_inv_err"}, 32'(ierrs), 0);
   endtask

   task automatic full_frame(input string tag, input logic [7:0] a, input logic [7:0] c);
      int s;
      wr(2'd0, a);
      wr(2'd1, c);
      m_addr = a;
      m_cmd  = c;
      build_frame(1'b0, a, c);
      wr(2'd2, 8'h01);
      s = last_edge;
      check_wave(tag, s, 20);
   endtask

   initial begin
      logic [1:0] adr;
      logic [7:0] d;
      int s;
      int total;
      int errs;
      int rst_cyc;

      drive(1'b0, 1'b0, 2'd0, 8'h00);
      rst = 1'b1;
      m_addr = 8'h00;
      m_cmd  = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_led", 32'(led0), 0);
      check("reset_led_inv", 32'(led1), 1);
      @(posedge clk); #1;

      rd_check("reset_addr", 2'd0, 8'h00);
      rd_check("reset_cmd", 2'd1, 8'h00);
      rd_check("reset_busy", 2'd2, 8'h00);
      rd_check("reg3", 2'd3, 8'h00);

      // Random register traffic on ADDR/CMD/unused slot
      for (int i = 0; i < 10; i++) begin
         adr = 2'($urandom_range(0, 2));
         if (adr == 2'd2) adr = 2'd3;
         d = 8'($urandom);
         wr(adr, d);
         if (adr == 2'd0) m_addr = d;
         if (adr == 2'd1) m_cmd  = d;
         adr = 2'($urandom_range(0, 2));
         if (adr == 2'd2) adr = 2'd3;
         rd_check("reg_rb", adr, (adr == 2'd0) ? m_addr : (adr == 2'd1) ? m_cmd : 8'h00);
      end

      // Full frame ADDR=00 CMD=01 with busy edges pinned
      wr(2'd0, 8'h00);
      wr(2'd1, 8'h01);
      build_frame(1'b0, 8'h00, 8'h01);
      wr(2'd2, 8'h01);
      s = last_edge;
      total = frame_cycles();
      wait_to(s + 99);
      rd_check("busy_mid", 2'd2, 8'h01);
      wait_to(s + total - 1);
      rd_check("busy_last", 2'd2, 8'h01);
      check_wave("frame0001", s, 20);
      rd_check("busy_after", 2'd2, 8'h00);

      // Repeat code
      build_frame(1'b1, 8'h00, 8'h00);
      wr(2'd2, 8'h02);
      s = last_edge;
      total = frame_cycles();
      wait_to(s + total - 6);
      rd_check("rep_busy", 2'd2, 8'h01);
      wait_to(s + total);
      rd_check("rep_idle", 2'd2, 8'h00);
      check_wave("repeat", s, 20);

      // Writes during a frame do not disturb it; starts while busy are dropped
      m_addr = 8'($urandom);
      m_cmd  = 8'($urandom);
      wr(2'd0, m_addr);
      wr(2'd1, m_cmd);
      build_frame(1'b0, m_addr, m_cmd);
      wr(2'd2, 8'h01);
      s = last_edge;
      wait_to(s + 300);
      wr(2'd1, 8'h55);
      wr(2'd2, 8'h01);
      wr(2'd2, 8'h02);
      wr(2'd0, 8'hC3);
      rd_check("cmd_upd", 2'd1, 8'h55);
      rd_check("addr_upd", 2'd0, 8'hC3);
      check_wave("busy_writes", s, 3 * TICK);
      m_cmd  = 8'h55;
      m_addr = 8'hC3;

      // Both start bits while idle: full frame wins
      build_frame(1'b0, m_addr, m_cmd);
      wr(2'd2, 8'h03);
      s = last_edge;
      check_wave("both_bits", s, 20);

      // Reset at tick 50 of a frame
      m_addr = 8'($urandom_range(1, 255));
      m_cmd  = 8'($urandom_range(1, 255));
      wr(2'd0, m_addr);
      wr(2'd1, m_cmd);
      wr(2'd2, 8'h01);
      s = last_edge;
      wait_to(s + 50 * TICK - 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst_cyc = cyc;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_led", 32'(led0), 0);
      check("rst_mid_led_inv", 32'(led1), 1);
      @(posedge clk); #1;
      rd_check("rst_mid_busy", 2'd2, 8'h00);
      rd_check("rst_mid_addr", 2'd0, 8'h00);
      rd_check("rst_mid_cmd", 2'd1, 8'h00);
      wait_to(rst_cyc + 10 * TICK);
      errs = 0;
      for (int j = rst_cyc; j < rst_cyc + 10 * TICK; j++)
         if (log0[j] != 1'b0 || log1[j] != 1'b1) errs++;
      check("rst_mid_quiet", 32'(errs), 0);

      // Random frames after reset
      for (int i = 0; i < 2; i++) begin
         full_frame("rand_frame", 8'($urandom), 8'($urandom));
         rd_check("rand_addr_rb", 2'd0, m_addr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/irencoder_wb8.md
Name: irencoder_wb8

Overview:
- Wishbone 8-bit responder that transmits NEC-protocol infrared frames on an IR LED pin. It is the transmit counterpart to irdecoder_wb8.
- It sits in the 0xFFFFFBxx slot of the bus arbiter. The CPU loads address and command bytes, then starts a full frame or a repeat code.
- The block generates all timing and the modulated carrier, and reports busy status.

Parameters:
- CLOCKFREQ, 25125000: bus clock frequency in Hz.
- CARRIERFREQ, 38000: IR carrier frequency in Hz.
- INVERT, 0: when 1, O_ir_led is inverted, for an active-low LED driver.

Ports:
- I_wb_clk  in  1  bus clock; the only clock.
- I_reset  in  1  synchronous, active-high reset.
- I_wb_adr  in  2  register select.
- I_wb_dat  in  8  write data.
- I_wb_stb  in  1  strobe.
- I_wb_we  in  1  write enable.
- O_wb_dat  out  8  read data.
- O_wb_ack  out  1  acknowledge.
- O_ir_led  out  1  modulated IR LED drive.

Behaviour:
- Derived localparams:
  - TICK = CLOCKFREQ*9/16000 cycles (562.5 us unit, integer truncation).
  - CPER = CLOCKFREQ/CARRIERFREQ.
  - CHIGH = CPER/3.
- Bus:
  - O_wb_ack is registered: it is high in the cycle after each cycle with I_wb_stb=1, for reads and writes, and low otherwise.
  - A write takes effect at the clock edge where stb&we are sampled.
  - O_wb_dat is registered on the same edge.
- Registers:
  - adr 0: ADDR (r/w).
  - adr 1: CMD (r/w).
  - adr 2, write: CTRL. Bit0 starts a full frame; bit1 starts a repeat code.
  - adr 2, read: {7'b0, busy}.
  - adr 3: reads 0; writes are ignored.
- Reset values: ADDR=0, CMD=0, busy=0, O_wb_ack=0, O_wb_dat=0. FSM goes to IDLE. O_ir_led is INVERT (LED off).
- Start while IDLE:
  - Frame start: a 32-bit shift register latches {~CMD, CMD, ~ADDR, ADDR}; bits are sent LSB first starting with ADDR bit0.
  - busy rises on the same edge as the start write.
  - Writing ADDR/CMD while busy updates the registers but does not affect the frame in flight.
- Start while busy: ignored. If bit0 and bit1 are both set, the full frame wins.
- FSM states and durations (N is in ticks):

  | State | Duration | Carrier | Next state |
  |---|---|---|---|
  | IDLE | — | — | — |
  | HDR_MARK | 16 | on | full frame: HDR_SPACE (8); repeat: REP_SPACE (4) |
  | BIT_MARK | 1 | on | BIT_SPACE |
  | BIT_SPACE | 1 (bit 0) or 3 (bit 1) | off | BIT_MARK (32 bits total) |
  | STOP_MARK | 1 | on | GUARD |
  | GUARD | 72 | off | IDLE |

  - Full frame: HDR_SPACE is followed by 32 BIT_MARK/BIT_SPACE pairs.
  - Repeat code: REP_SPACE goes straight to STOP_MARK.
  - busy falls on the edge that enters IDLE.
- Timing counters:
  - A tick counter restarts at every state entry. A state of N ticks lasts exactly N*TICK cycles.
  - A bit counter counts 0..31; after bit 31's space the FSM goes to STOP_MARK.
- Carrier:
  - The carrier counter counts 0..CPER-1 and wraps.
  - It resets to 0 on entry to every mark state, so each mark begins in the high phase.
  - During mark states, O_ir_led = INVERT ^ (carrier_cnt < CHIGH). Elsewhere it is INVERT.
  - O_ir_led is registered, giving one cycle of latency relative to the state.
- Reset mid-frame: the next edge returns the FSM to IDLE with LED off and all registers cleared. There is no partial-frame completion.

Decomposition:
- Shared include irdefs.vh holds the NEC tick-count localparams (16, 8, 4, 1, 3, 72) and the formula for the 562.5 us unit. irdecoder_wb8 uses the same include.
- FSM state encodings stay local to the module.
- One sub-module, ir_carrier: CPER/CHIGH counter with a sync restart input and an enable; it outputs the carrier phase.

Test Plan (CLOCKFREQ=1600000, CARRIERFREQ=100000, giving TICK=900, CPER=16, CHIGH=5):
1. Reset, then read adr 0, 1, 2 -> all 0x00. Each access gives exactly one ack, one cycle after stb. O_ir_led stays 0.
2. ADDR=0x00, CMD=0x01, CTRL=0x01 ->
   - First mark lasts 14400 cycles of a 5-high/11-low pattern; the space is 7200 cycles.
   - Decoded space lengths give bytes 00, FF, 01, FE, LSB first.
   - busy stays high for 193 ticks = 173700 cycles, then reads 0.
3. CTRL=0x02 -> 14400-cycle mark, 3600-cycle space, 900-cycle mark. busy lasts 93 ticks = 83700 cycles.
4. During a frame:
   - write CMD=0x55 and CTRL=0x01 -> the transmitted frame is unchanged and no second frame follows;
   - CTRL=0x03 while IDLE -> a full frame is sent.
5. Assert I_reset at tick 50 of a frame -> the next cycle has O_ir_led=0, busy=0, ADDR=CMD=0. A new start afterwards produces a correct frame.
6. INVERT=1 -> the waveform is the exact complement of scenario 2, and idle level is 1.
